// File: rtl/csc_frame_ctrl_if.sv
// Host configuration channel for csc_frame_ctrl: valid/ready transfer of a 2-bit output mode.
`timescale 1ns / 1ps

interface csc_frame_ctrl_if;
  logic [1:0] cfg_mode;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_mode, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_mode, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/csc_frame_ctrl.sv
// Frame-synchronous output selector and geometry monitor for the colour-space converter.
// Geometry statistics are built only when CSC_FRAME_CTRL_STATS_EN is defined.
`timescale 1ns / 1ps

module csc_frame_ctrl #(
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        i_rgb,
  input  logic [23:0]        i_ycbcr,
  input  logic [23:0]        i_gray,
  input  logic               i_h_sync,
  input  logic               i_v_sync,
  input  logic               i_data_en,
  csc_frame_ctrl_if.slave    cfg,
  output logic [23:0]        o_pix,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_data_en,
  output logic [1:0]         o_mode,
  output logic [CNT_W-1:0]   o_line_width,
  output logic [CNT_W-1:0]   o_frame_height,
  output logic               o_geom_err,
  output logic [15:0]        o_frame_cnt
);

  typedef enum logic [0:0] {StWait, StRun} state_e;

  state_e      state_q;
  logic        v_act_q;
  logic [1:0]  mode_q;
  logic        pend_valid_q;
  logic [1:0]  pend_mode_q;

  logic        v_act;
  logic        vs_start;
  logic        apply;
  logic [1:0]  eff_mode;
  logic [23:0] sel_pix;

  // A pending mode takes effect on the vs_start sample itself, not one cycle later.
  always_comb begin
    v_act    = (i_v_sync == SYNC_POL);
    vs_start = v_act && !v_act_q;
    apply    = vs_start && pend_valid_q;
    eff_mode = apply ? pend_mode_q : mode_q;
    sel_pix  = '0;
    unique case (eff_mode)
      2'b00:   sel_pix = i_rgb;
      2'b01:   sel_pix = i_ycbcr;
      2'b10:   sel_pix = i_gray;
      default: sel_pix = '0;
    endcase
  end

  assign cfg.cfg_ready = !pend_valid_q;
  assign o_mode        = mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWait;
      v_act_q      <= 1'b0;
      mode_q       <= 2'b00;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= 2'b00;
      o_pix        <= '0;
      o_h_sync     <= !SYNC_POL;
      o_v_sync     <= !SYNC_POL;
      o_data_en    <= 1'b0;
    end else begin
      v_act_q  <= v_act;
      o_h_sync <= i_h_sync;
      o_v_sync <= i_v_sync;
      // Apply and accept are exclusive: apply needs pending, accept needs it empty.
      if (apply) begin
        mode_q       <= pend_mode_q;
        pend_valid_q <= 1'b0;
      end else if (cfg.cfg_valid && !pend_valid_q) begin
        pend_valid_q <= 1'b1;
        pend_mode_q  <= cfg.cfg_mode;
      end
      case (state_q)
        StWait: begin
          o_pix     <= '0;
          o_data_en <= 1'b0;
          if (vs_start) state_q <= StRun;
        end
        StRun: begin
          o_pix     <= sel_pix;
          o_data_en <= i_data_en;
        end
        default: state_q <= StWait;
      endcase
    end
  end

`ifdef CSC_FRAME_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             de_q;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] v_cnt_q;
  logic [CNT_W-1:0] ref_width_q;
  logic             ref_valid_q;
  logic             mismatch_q;
  logic             skip_q;
  logic             line_end;

  assign line_end = de_q && !i_data_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q           <= 1'b0;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      ref_width_q    <= '0;
      ref_valid_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      skip_q         <= 1'b0;
      o_line_width   <= '0;
      o_frame_height <= '0;
      o_geom_err     <= 1'b0;
      o_frame_cnt    <= '0;
    end else begin
      de_q <= i_data_en;
      if (state_q == StWait) begin
        h_cnt_q     <= '0;
        v_cnt_q     <= '0;
        ref_width_q <= '0;
        ref_valid_q <= 1'b0;
        mismatch_q  <= 1'b0;
        skip_q      <= 1'b0;
      end else if (vs_start) begin
        o_line_width   <= ref_width_q;
        o_frame_height <= v_cnt_q;
        o_geom_err     <= mismatch_q || i_data_en;
        o_frame_cnt    <= o_frame_cnt + 16'd1;
        h_cnt_q        <= '0;
        v_cnt_q        <= '0;
        ref_width_q    <= '0;
        ref_valid_q    <= 1'b0;
        mismatch_q     <= 1'b0;
        // A line cut by vs_start is ignored until its data enable falls.
        skip_q         <= i_data_en;
      end else if (line_end) begin
        h_cnt_q <= '0;
        if (skip_q) begin
          skip_q <= 1'b0;
        end else begin
          if (!ref_valid_q) begin
            ref_width_q <= h_cnt_q;
            ref_valid_q <= 1'b1;
          end else if (h_cnt_q != ref_width_q) begin
            mismatch_q <= 1'b1;
          end
          if (v_cnt_q != CntMax) v_cnt_q <= v_cnt_q + 1'b1;
        end
      end else if (i_data_en && !skip_q && (h_cnt_q != CntMax)) begin
        h_cnt_q <= h_cnt_q + 1'b1;
      end
    end
  end
`else
  assign o_line_width   = '0;
  assign o_frame_height = '0;
  assign o_geom_err     = 1'b0;
  assign o_frame_cnt    = '0;
`endif

endmodule

// File: tb/tb_csc_frame_ctrl.sv
// Self-checking bench for csc_frame_ctrl: per-cycle stream scoreboard plus scenario checks.
`timescale 1ns / 1ps

module tb_csc_frame_ctrl;
  localparam int H_ACT = 64;
  localparam int V_ACT = 8;
`ifdef CSC_FRAME_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] pix;
    logic        h;
    logic        v;
    logic        de;
    logic [1:0]  mode;
    logic        ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb, ycbcr, gray;
  logic        h, v, de;
  logic [23:0] o_pix;
  logic        o_h_sync, o_v_sync, o_data_en, o_geom_err;
  logic [1:0]  o_mode;
  logic [11:0] o_line_width, o_frame_height;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // Reference model state
  bit          m_run, m_pend, m_vprev;
  logic [1:0]  m_mode, m_pend_mode;
  logic [23:0] last_rgb, last_ycbcr, last_gray;

  csc_frame_ctrl_if cfg_if ();

  csc_frame_ctrl #(.SYNC_POL(1'b1), .CNT_W(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rgb          (rgb),
    .i_ycbcr        (ycbcr),
    .i_gray         (gray),
    .i_h_sync       (h),
    .i_v_sync       (v),
    .i_data_en      (de),
    .cfg            (cfg_if),
    .o_pix          (o_pix),
    .o_h_sync       (o_h_sync),
    .o_v_sync       (o_v_sync),
    .o_data_en      (o_data_en),
    .o_mode         (o_mode),
    .o_line_width   (o_line_width),
    .o_frame_height (o_frame_height),
    .o_geom_err     (o_geom_err),
    .o_frame_cnt    (o_frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pick(input logic [1:0] m, input logic [23:0] a, b, c);
    case (m)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [40:0] st(input int w, input int ht, input int e, input int f);
    return STATS ? {12'(w), 12'(ht), 1'(e), 16'(f)} : 41'd0;
  endfunction

  // Drive one sample; the expected registered output is queued at the sampling edge.
  task automatic step(input logic hh, input logic vv, input logic dd, input logic cv,
                      input logic [1:0] cm);
    exp_t e;
    logic vs;
    logic [1:0] em;
    h = hh; v = vv; de = dd;
    cfg_if.cfg_valid = cv;
    cfg_if.cfg_mode  = cm;
    rgb   = 24'($urandom());
    ycbcr = 24'($urandom());
    gray  = 24'($urandom());
    last_rgb = rgb; last_ycbcr = ycbcr; last_gray = gray;
    @(posedge clk);
    vs = vv && !m_vprev;
    em = (vs && m_pend) ? m_pend_mode : m_mode;
    e.pix = m_run ? pick(em, rgb, ycbcr, gray) : 24'h0;
    e.h   = hh;
    e.v   = vv;
    e.de  = m_run && dd;
    if (vs && m_pend) begin
      m_mode = m_pend_mode;
      m_pend = 1'b0;
    end else if (cv && !m_pend) begin
      m_pend      = 1'b1;
      m_pend_mode = cm;
    end
    if (vs) m_run = 1'b1;
    m_vprev = vv;
    e.mode  = m_mode;
    e.ready = !m_pend;
    sb_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {o_pix, o_h_sync, o_v_sync, o_data_en, o_mode, cfg_if.cfg_ready};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stream at %0t: got %h want %h", $time, got, e);
      end
    end
  end

  task automatic lines(input int n, input int bad);
    for (int l = 0; l < n; l++) begin
      for (int p = 0; p < ((l == bad) ? H_ACT - 1 : H_ACT); p++) step(0, 0, 1, 0, 2'b00);
      step(1, 0, 0, 0, 2'b00);
      step(1, 0, 0, 0, 2'b00);
      step(0, 0, 0, 0, 2'b00);
      step(0, 0, 0, 0, 2'b00);
    end
  endtask

  // Everything of a frame after its vs_start sample.
  task automatic frame_rest(input int bad);
    step(1, 1, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    lines(V_ACT, bad);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    h = 1'b1; v = 1'b0; de = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode  = 2'b10;
    rgb = 24'h123456; ycbcr = 24'h654321; gray = 24'habcdef;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_run = 0; m_pend = 0; m_vprev = 0; m_mode = 2'b00; m_pend_mode = 2'b00;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({o_pix, o_h_sync, o_v_sync, o_data_en} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {o_pix, o_h_sync, o_v_sync, o_data_en});
    end
    checks++;
    if (o_mode !== 2'b00 || cfg_if.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mode_ready: got %b/%b want 00/1", o_mode, cfg_if.cfg_ready);
    end
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== 41'd0) begin
      errors++;
      $display("FAIL reset_stats: got %h want 0",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_wait_frame();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 2'b00);
      checks++;
      if (o_data_en !== 1'b0 || o_pix !== 24'h0) begin
        errors++;
        $display("FAIL wait_gating: got de=%b pix=%h want 0/0", o_data_en, o_pix);
      end
    end
    step(0, 0, 0, 0, 2'b00);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL first_vs_no_latch: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(0, 0, 0, 0));
    end
    frame_rest(-1);
  endtask

  task automatic test_geometry();
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 0, 1)) begin
      errors++;
      $display("FAIL geometry_frame1: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(H_ACT, V_ACT, 0, 1));
    end
  endtask

  task automatic test_mode_switch();
    step(1, 1, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    lines(V_ACT / 2, -1);
    step(0, 0, 0, 1, 2'b10);
    checks++;
    if (cfg_if.cfg_ready !== 1'b0 || o_mode !== 2'b00 || o_pix !== last_rgb) begin
      errors++;
      $display("FAIL switch_request: got rdy=%b mode=%b pix=%h want 0/00/%h",
               cfg_if.cfg_ready, o_mode, o_pix, last_rgb);
    end
    lines(V_ACT / 2, -1);
    checks++;
    if (o_mode !== 2'b00 || o_pix !== last_rgb) begin
      errors++;
      $display("FAIL switch_held: got mode=%b pix=%h want 00/%h", o_mode, o_pix, last_rgb);
    end
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if (o_mode !== 2'b10 || cfg_if.cfg_ready !== 1'b1 || o_pix !== last_gray) begin
      errors++;
      $display("FAIL switch_applied: got mode=%b rdy=%b pix=%h want 10/1/%h",
               o_mode, cfg_if.cfg_ready, o_pix, last_gray);
    end
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 0, 2)) begin
      errors++;
      $display("FAIL geometry_frame2: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(H_ACT, V_ACT, 0, 2));
    end
  endtask

  task automatic test_same_cycle_req();
    frame_rest(-1);
    step(1, 1, 0, 1, 2'b01);
    checks++;
    if (o_mode !== 2'b10 || cfg_if.cfg_ready !== 1'b0 || o_pix !== last_gray) begin
      errors++;
      $display("FAIL same_cycle_deferred: got mode=%b rdy=%b pix=%h want 10/0/%h",
               o_mode, cfg_if.cfg_ready, o_pix, last_gray);
    end
    frame_rest(-1);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if (o_mode !== 2'b01 || cfg_if.cfg_ready !== 1'b1 || o_pix !== last_ycbcr) begin
      errors++;
      $display("FAIL same_cycle_applied: got mode=%b rdy=%b pix=%h want 01/1/%h",
               o_mode, cfg_if.cfg_ready, o_pix, last_ycbcr);
    end
  endtask

  task automatic test_geom_err();
    frame_rest(3);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 1, 5)) begin
      errors++;
      $display("FAIL geom_short_line: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(H_ACT, V_ACT, 1, 5));
    end
    frame_rest(-1);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 0, 6)) begin
      errors++;
      $display("FAIL geom_clean_after: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(H_ACT, V_ACT, 0, 6));
    end
  endtask

  task automatic test_vs_during_de();
    frame_rest(-1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 2'b00);
    step(1, 1, 1, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 1, 7)) begin
      errors++;
      $display("FAIL vs_in_active: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(H_ACT, V_ACT, 1, 7));
    end
    frame_rest(-1);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 0, 8)) begin
      errors++;
      $display("FAIL partial_discarded: got %h want %h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, st(H_ACT, V_ACT, 0, 8));
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    lines(3, -1);
    step(0, 0, 0, 1, 2'b11);
    step(0, 0, 1, 0, 2'b00);
    reset_dut();
    checks++;
    if (o_mode !== 2'b00 || cfg_if.cfg_ready !== 1'b1 || o_pix !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid: got mode=%b rdy=%b pix=%h want 00/1/0",
               o_mode, cfg_if.cfg_ready, o_pix);
    end
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== 41'd0) begin
      errors++;
      $display("FAIL reset_mid_stats: got %h want 0",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b00);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if (o_frame_cnt !== 16'd0 || o_mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_first_vs: got cnt=%0d mode=%b want 0/00", o_frame_cnt, o_mode);
    end
    frame_rest(-1);
    step(1, 1, 0, 0, 2'b00);
    checks++;
    if ({o_line_width, o_frame_height, o_geom_err, o_frame_cnt} !== st(H_ACT, V_ACT, 0, 1)
        || o_mode !== 2'b00 || o_pix !== last_rgb) begin
      errors++;
      $display("FAIL reset_recovery: got %h mode=%b pix=%h want %h/00/%h",
               {o_line_width, o_frame_height, o_geom_err, o_frame_cnt}, o_mode, o_pix,
               st(H_ACT, V_ACT, 0, 1), last_rgb);
    end
  endtask

  initial begin
    rst = 1'b1;
    h = 1'b0; v = 1'b0; de = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode  = 2'b00;
    rgb = '0; ycbcr = '0; gray = '0;
    test_reset();
    test_wait_frame();
    test_geometry();
    test_mode_switch();
    test_same_cycle_req();
    test_geom_err();
    test_vs_during_de();
    test_reset_mid();
    step(0, 0, 0, 0, 2'b00);
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
